dram_port_arbiter: RTL and testbench

Sequencer that shares the single byte-wide DRAM port between the instruction-fetch path (port 0) and the data cache refill/writeback path (port 1). It accepts 32-bit word read/write requests, serializes each into four byte beats on the DRAM handshake, and reassembles read data little-endian. It returns a one-cycle acknowledge to the granted requester. The block sits between the fetch/cache side and the DRAM model, and drives the DRAM command pins directly.

---
 rtl/dram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//
// Shares the single byte-wide DRAM port between instruction fetch (port 0)
// and the data cache refill/writeback path (port 1). Each 32-bit word
// request is split into four byte beats on the DRAM handshake. Read bytes
// are reassembled little-endian, and the granted port gets a one-cycle ack.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req0/req1           request, held with stable command until ack
//   we0/we1             1 = word write, 0 = word read
//   addr0/addr1         byte address, bits [1:0] ignored
//   wdata0/wdata1       write word
//   ack0/ack1           one-cycle completion pulse
//   rdata               last completed read word, valid during ack
//   busy                high whenever the sequencer is not idle
//   dram_signal         00 idle, 01 read byte, 10 write byte
//   dram_addr_rd/_wr    byte address for read / write beats
//   dram_write_data     write byte
//   dram_ready          DRAM beat complete (only honoured while waiting)
//   dram_result         read byte, valid with dram_ready
//
// Build option:
//   DRAM_ARB_ROUND_ROBIN_EN  defined   -> ties go to the port not granted last
//                            undefined -> fixed priority, port 1 wins ties
//
// All outputs come straight from registers.

module dram_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [1:0]  dram_signal,
    output logic [31:0] dram_addr_rd,
    output logic [31:0] dram_addr_wr,
    output logic [7:0]  dram_write_data,
    input  logic        dram_ready,
    input  logic [7:0]  dram_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state, w_stateNext;
    logic [1:0]  r_beat, w_beatNext;
    logic        r_cmdWe, w_cmdWeNext;
    logic [31:0] r_cmdBase, w_cmdBaseNext;
    logic [31:0] r_cmdWdata, w_cmdWdataNext;
    logic        r_grant, w_grantNext;
    logic [23:0] r_rbuf, w_rbufNext;

    logic        r_ack0, w_ack0Next;
    logic        r_ack1, w_ack1Next;
    logic [31:0] r_rdata, w_rdataNext;
    logic        r_busy, w_busyNext;
    logic [1:0]  r_dramSignal, w_dramSignalNext;
    logic [31:0] r_addrRd, w_addrRdNext;
    logic [31:0] r_addrWr, w_addrWrNext;
    logic [7:0]  r_wrData, w_wrDataNext;

    logic        w_anyReq;
    logic        w_grantSel;
    logic        w_selWe;
    logic [31:0] w_selAddr;
    logic [31:0] w_selWdata;

    logic        w_issue;
    logic        w_issueWe;
    logic [31:0] w_issueBase;
    logic [31:0] w_issueWdata;
    logic [1:0]  w_issueBeat;
    logic [31:0] w_issueAddr;
    logic [7:0]  w_issueByte;

    assign w_anyReq = req0 | req1;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    logic r_lastGrant;

    // Remembers the port of the most recent grant so a tie goes the other way.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrant <= 1'b1;
        end else if (r_state == IDLE && w_anyReq) begin
            r_lastGrant <= w_grantSel;
        end
    end

    assign w_grantSel = (req0 && req1) ? ~r_lastGrant : req1;
`else
    // Port 1 (data cache) wins any tie.
    assign w_grantSel = req1;
`endif

    assign w_selWe    = w_grantSel ? we1    : we0;
    assign w_selAddr  = w_grantSel ? addr1  : addr0;
    assign w_selWdata = w_grantSel ? wdata1 : wdata0;

    // Next-state and next-output logic. Beat issue is computed once from
    // w_issue* so the IDLE->ISSUE and WAIT->ISSUE paths share one address
    // and data formation.
    always_comb begin
        w_stateNext      = r_state;
        w_beatNext       = r_beat;
        w_cmdWeNext      = r_cmdWe;
        w_cmdBaseNext    = r_cmdBase;
        w_cmdWdataNext   = r_cmdWdata;
        w_grantNext      = r_grant;
        w_rbufNext       = r_rbuf;
        w_ack0Next       = 1'b0;
        w_ack1Next       = 1'b0;
        w_rdataNext      = r_rdata;
        w_dramSignalNext = 2'b00;
        w_addrRdNext     = r_addrRd;
        w_addrWrNext     = r_addrWr;
        w_wrDataNext     = r_wrData;
        w_issue          = 1'b0;
        w_issueWe        = r_cmdWe;
        w_issueBase      = r_cmdBase;
        w_issueWdata     = r_cmdWdata;
        w_issueBeat      = r_beat;
        w_issueAddr      = 32'd0;
        w_issueByte      = 8'd0;

        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_cmdWeNext    = w_selWe;
                    w_cmdBaseNext  = w_selAddr & 32'hFFFF_FFFC;
                    w_cmdWdataNext = w_selWdata;
                    w_grantNext    = w_grantSel;
                    w_beatNext     = 2'd0;
                    w_stateNext    = ISSUE;
                    w_issue        = 1'b1;
                    w_issueWe      = w_selWe;
                    w_issueBase    = w_selAddr & 32'hFFFF_FFFC;
                    w_issueWdata   = w_selWdata;
                    w_issueBeat    = 2'd0;
                end
            end
            ISSUE: begin
                w_stateNext = WAIT;
            end
            WAIT: begin
                if (dram_ready) begin
                    // Bytes 0..2 collect in a side buffer; rdata only changes
                    // when the whole word is in, so it stays stable until then.
                    if (!r_cmdWe) begin
                        case (r_beat)
                            2'd0:    w_rbufNext[7:0]   = dram_result;
                            2'd1:    w_rbufNext[15:8]  = dram_result;
                            2'd2:    w_rbufNext[23:16] = dram_result;
                            default: w_rdataNext       = {dram_result, r_rbuf};
                        endcase
                    end
                    if (r_beat == 2'd3) begin
                        w_stateNext = DONE;
                        w_ack0Next  = ~r_grant;
                        w_ack1Next  = r_grant;
                    end else begin
                        w_beatNext  = r_beat + 2'd1;
                        w_stateNext = ISSUE;
                        w_issue     = 1'b1;
                        w_issueBeat = r_beat + 2'd1;
                    end
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        // The base is word aligned, so OR-ing in the beat never carries.
        w_issueAddr = w_issueBase | {30'd0, w_issueBeat};
        w_issueByte = w_issueWdata[{w_issueBeat, 3'b000} +: 8];

        if (w_issue) begin
            if (w_issueWe) begin
                w_dramSignalNext = 2'b10;
                w_addrWrNext     = w_issueAddr;
                w_wrDataNext     = w_issueByte;
            end else begin
                w_dramSignalNext = 2'b01;
                w_addrRdNext     = w_issueAddr;
            end
        end

        w_busyNext = (w_stateNext != IDLE);
    end

    // State and registered outputs. Reset also discards any partial read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat       <= 2'd0;
            r_cmdWe      <= 1'b0;
            r_cmdBase    <= 32'd0;
            r_cmdWdata   <= 32'd0;
            r_grant      <= 1'b0;
            r_rbuf       <= 24'd0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata      <= 32'd0;
            r_busy       <= 1'b0;
            r_dramSignal <= 2'b00;
            r_addrRd     <= 32'd0;
            r_addrWr     <= 32'd0;
            r_wrData     <= 8'd0;
        end else begin
            r_state      <= w_stateNext;
            r_beat       <= w_beatNext;
            r_cmdWe      <= w_cmdWeNext;
            r_cmdBase    <= w_cmdBaseNext;
            r_cmdWdata   <= w_cmdWdataNext;
            r_grant      <= w_grantNext;
            r_rbuf       <= w_rbufNext;
            r_ack0       <= w_ack0Next;
            r_ack1       <= w_ack1Next;
            r_rdata      <= w_rdataNext;
            r_busy       <= w_busyNext;
            r_dramSignal <= w_dramSignalNext;
            r_addrRd     <= w_addrRdNext;
            r_addrWr     <= w_addrWrNext;
            r_wrData     <= w_wrDataNext;
        end
    end

    assign ack0            = r_ack0;
    assign ack1            = r_ack1;
    assign rdata           = r_rdata;
    assign busy            = r_busy;
    assign dram_signal     = r_dramSignal;
    assign dram_addr_rd    = r_addrRd;
    assign dram_addr_wr    = r_addrWr;
    assign dram_write_data = r_wrData;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter
//
// Scoreboard bench for dram_port_arbiter. Each launched request pushes its
// four expected DRAM beats and its expected ack (port, rdata, cycle) onto
// queues. Every negative clock edge the monitor pops and compares whatever
// the DUT presents. A small byte memory answers read beats. dram_ready can
// be pulled low for a chosen beat to model a stall.

module tb_dram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata;
    logic        busy;
    logic [1:0]  dram_signal;
    logic [31:0] dram_addr_rd, dram_addr_wr;
    logic [7:0]  dram_write_data;
    logic        dram_ready;
    logic [7:0]  dram_result;

    always #5 clk = ~clk;

    dram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .dram_signal(dram_signal), .dram_addr_rd(dram_addr_rd),
        .dram_addr_wr(dram_addr_wr), .dram_write_data(dram_write_data),
        .dram_ready(dram_ready), .dram_result(dram_result)
    );

    logic [7:0] mem [0:511];
    assign dram_result = mem[dram_addr_rd[8:0]];

    typedef struct {
        logic [1:0]  sig;
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        int          cycle;
    } ack_t;

    beat_t beatQ[$];
    ack_t  ackQ[$];

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int issueCnt = 0;
    int stallIssue = -1;
    int stallLen = 0;
    int stallLeft = 0;
    logic [31:0] modelRdata;
    logic        modelLastGrant;

    // Tie-test commands: index 0 and 1 are the two rounds
    logic        tieWe0 [2];
    logic        tieWe1 [2];
    logic [31:0] tieAddr0 [2];
    logic [31:0] tieAddr1 [2];
    logic [31:0] tieData0 [2];
    logic [31:0] tieData1 [2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next negative edge and run the monitor/DRAM model there.
    task automatic tick();
        beat_t b;
        ack_t  a;
        @(negedge clk);
        cycleCnt++;
        if (dram_signal != 2'b00) begin
            issueCnt++;
            if (beatQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL beatUnexpected got signal=%b addrRd=0x%08h addrWr=0x%08h exp no beat",
                         dram_signal, dram_addr_rd, dram_addr_wr);
            end else begin
                b = beatQ.pop_front();
                checkOutput("beatSignal", {30'd0, dram_signal}, {30'd0, b.sig});
                if (b.sig == 2'b10) begin
                    checkOutput("beatAddrWr", dram_addr_wr, b.addr);
                    checkOutput("beatData", {24'd0, dram_write_data}, {24'd0, b.data});
                end else begin
                    checkOutput("beatAddrRd", dram_addr_rd, b.addr);
                end
            end
            if (issueCnt == stallIssue) begin
                dram_ready = 1'b0;
                stallLeft  = stallLen + 1;
            end
        end else if (stallLeft > 0) begin
            stallLeft--;
            if (stallLeft == 0) dram_ready = 1'b1;
        end
        if (ack0 || ack1) begin
            checkOutput("twoAcks", {31'd0, ack0 & ack1}, 32'd0);
            checkOutput("ackBusy", {31'd0, busy}, 32'd1);
            if (ackQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL ackUnexpected got ack0=%b ack1=%b exp none", ack0, ack1);
            end else begin
                a = ackQ.pop_front();
                checkOutput("ackPort", ack1 ? 32'd1 : 32'd0, a.port);
                checkOutput("ackRdata", rdata, a.rdata);
                checkOutput("ackCycle", cycleCnt, a.cycle);
            end
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
    endtask

    // Push the expected beats and ack for one transaction onto the scoreboard.
    task automatic expectTransaction(input int port, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input int expCycle);
        logic [31:0] base;
        logic [31:0] word;
        beat_t b;
        ack_t  a;
        base = addr & 32'hFFFF_FFFC;
        word = 32'd0;
        for (int i = 0; i < 4; i++) begin
            b.sig  = we ? 2'b10 : 2'b01;
            b.addr = base + i;
            b.data = we ? wdata[8*i +: 8] : 8'h00;
            word[8*i +: 8] = mem[b.addr[8:0]];
            beatQ.push_back(b);
        end
        if (!we) modelRdata = word;
        a.port  = port;
        a.rdata = modelRdata;
        a.cycle = expCycle;
        ackQ.push_back(a);
        modelLastGrant = (port != 0);
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (port == 0) begin
            we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
        end
    endtask

    // Drain the scoreboard within a cycle budget, then one idle cycle.
    task automatic runUntilDone(input int budget);
        int n = 0;
        while ((beatQ.size() > 0 || ackQ.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        if (beatQ.size() > 0 || ackQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout got pending beats=%0d acks=%0d exp 0", beatQ.size(), ackQ.size());
            beatQ.delete();
            ackQ.delete();
            req0 = 1'b0;
            req1 = 1'b0;
        end
        tick();
        checkOutput("idleBusy", {31'd0, busy}, 32'd0);
    endtask

    task automatic runSingle(input int port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int extra);
        expectTransaction(port, we, addr, wdata, cycleCnt + 9 + extra);
        applyStimulus(port, we, addr, wdata);
        tick();
        checkOutput("busyAfterReq", {31'd0, busy}, 32'd1);
        runUntilDone(60);
    endtask

    initial begin
        int c;
        int target;
        int n;
        int win;

        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        mem[9'h100] = 8'h11; mem[9'h101] = 8'h22; mem[9'h102] = 8'h33; mem[9'h103] = 8'h44;

        tieWe0[0] = 1'b0; tieAddr0[0] = 32'h40;  tieData0[0] = 32'h0;
        tieWe1[0] = 1'b1; tieAddr1[0] = 32'h80;  tieData1[0] = 32'h12345678;
        tieWe0[1] = 1'b1; tieAddr0[1] = 32'hC0;  tieData0[1] = 32'hCAFEF00D;
        tieWe1[1] = 1'b0; tieAddr1[1] = 32'h150; tieData1[1] = 32'h0;

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        dram_ready = 1'b1;
        modelRdata = 32'd0;
        modelLastGrant = 1'b1;

        tick(); tick(); tick();
        checkOutput("rstAck0", {31'd0, ack0}, 32'd0);
        checkOutput("rstAck1", {31'd0, ack1}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstSignal", {30'd0, dram_signal}, 32'd0);
        checkOutput("rstAddrRd", dram_addr_rd, 32'd0);
        checkOutput("rstAddrWr", dram_addr_wr, 32'd0);
        checkOutput("rstWrData", {24'd0, dram_write_data}, 32'd0);
        checkOutput("rstRdata", rdata, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single read port 0");
        runSingle(0, 1'b0, 32'h103, 32'h0, 0);
        checkOutput("readWord", modelRdata, 32'h44332211);

        $display("[TB] single write port 1");
        runSingle(1, 1'b1, 32'h20, 32'hDEADBEEF, 0);

        $display("[TB] read with stall on beat 2");
        stallIssue = issueCnt + 3;
        stallLen   = 3;
        runSingle(0, 1'b0, 32'h1A4, 32'h0, 3);
        stallIssue = -1;

        $display("[TB] reset during beat 1 wait");
        expectTransaction(0, 1'b0, 32'h60, 32'h0, cycleCnt + 9);
        applyStimulus(0, 1'b0, 32'h60, 32'h0);
        target = issueCnt + 2;
        n = 0;
        while (issueCnt < target && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst  = 1'b1;
        req0 = 1'b0;
        tick();
        checkOutput("midRstSignal", {30'd0, dram_signal}, 32'd0);
        checkOutput("midRstRdata", rdata, 32'd0);
        checkOutput("midRstAck", {30'd0, ack1, ack0}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstBeatsLeft", beatQ.size(), 32'd2);
        beatQ.delete();
        ackQ.delete();
        modelRdata = 32'd0;
        modelLastGrant = 1'b1;
        rst = 1'b0;
        tick();
        runSingle(1, 1'b0, 32'h1C8, 32'h0, 0);

        $display("[TB] simultaneous requests");
        for (int t = 0; t < 2; t++) begin
            c = cycleCnt;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
            win = modelLastGrant ? 0 : 1;
`else
            win = 1;
`endif
            if (win == 0) begin
                expectTransaction(0, tieWe0[t], tieAddr0[t], tieData0[t], c + 9);
                expectTransaction(1, tieWe1[t], tieAddr1[t], tieData1[t], c + 19);
            end else begin
                expectTransaction(1, tieWe1[t], tieAddr1[t], tieData1[t], c + 9);
                expectTransaction(0, tieWe0[t], tieAddr0[t], tieData0[t], c + 19);
            end
            applyStimulus(0, tieWe0[t], tieAddr0[t], tieData0[t]);
            applyStimulus(1, tieWe1[t], tieAddr1[t], tieData1[t]);
            runUntilDone(80);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
